// File: rtl/song_player_sequencer_pkg.sv
// Shared definitions for the song player: system mode encodings, memory word
// layout widths and the end-of-song code.
package song_player_sequencer_pkg;

   localparam int DATA_W  = 8;
   localparam int NOTE_W  = 5;
   localparam int LEN_W   = 3;
   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] MODE_AUTOPLAY = 2'd1;
   localparam logic [STATE_W-1:0] MODE_LEARNING = 2'd2;
   localparam logic [STATE_W-1:0] MODE_GAME     = 2'd3;

   localparam logic [DATA_W-1:0] END_OF_SONG = 8'h00;

   function automatic logic is_play_mode(input logic [STATE_W-1:0] mode);
      return (mode == MODE_AUTOPLAY) || (mode == MODE_LEARNING) || (mode == MODE_GAME);
   endfunction

endpackage

// File: rtl/song_player_sequencer_beat_timer.sv
// Beat divider: counts cycles to (BEAT_CYCLES >> tempo) and emits beat_tick_o on the
// last cycle of each beat. Freezes while en_i is low; tempo is re-sampled every beat.
module song_player_sequencer_beat_timer #(
   parameter int BEAT_CYCLES = 25_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [1:0] tempo_sel_i,
   output logic       beat_tick_o
);

   localparam int CW = $clog2(BEAT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    tempo_q, tempo_d;
   logic [CW-1:0] limit;

   always_comb begin
      limit = CW'(BEAT_CYCLES) >> tempo_q;
      // A shift past the divider width would stall forever; clamp to one-cycle beats.
      if (limit == '0) limit = CW'(1);
      beat_tick_o = en_i && (cnt_q >= (limit - CW'(1)));
      cnt_d   = cnt_q;
      tempo_d = tempo_q;
      if (clr_i || beat_tick_o) begin
         cnt_d   = '0;
         tempo_d = tempo_sel_i;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         tempo_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         tempo_q <= tempo_d;
      end
   end

endmodule

// File: rtl/song_player_sequencer.sv
// Song player sequencer: fetches note words from memory, holds each note for its
// length in beats, inserts an articulation gap and detects end-of-song.
module song_player_sequencer
   import song_player_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int NOTE_WIDTH     = NOTE_W,
   parameter int LEN_WIDTH      = LEN_W,
   parameter int STATE_WIDTH    = STATE_W,
   parameter int BEAT_CYCLES    = 25_000_000,
   parameter int GAP_CYCLES     = 2_500_000,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STATE_WIDTH-1:0] current_state,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   pause,
   input  logic [1:0]             tempo_sel,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   output_ready,
   output logic                   read_en,
   output logic                   read_rst,
   output logic [NOTE_WIDTH-1:0]  note_out,
   output logic                   note_valid,
   output logic                   playing,
   output logic                   song_done,
   output logic                   fetch_error,
   output logic [7:0]             note_index
);

   typedef enum logic [2:0] {
      S_IDLE, S_REWIND, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_ERR
   } state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   // WAIT is entered one cycle after read_en, so the timeout fires one count early.
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0);

   state_t                state_q;
   logic [NOTE_WIDTH-1:0] note_q;
   logic [LEN_WIDTH-1:0]  len_q, beat_cnt_q;
   logic [TW-1:0]         tmo_q;
   logic [GW-1:0]         gap_cnt_q;
   logic                  read_en_q, read_rst_q, note_valid_q, playing_q;
   logic                  song_done_q, fetch_error_q;
   logic [NOTE_WIDTH-1:0] note_out_q;
   logic [7:0]            note_index_q;

   logic                  mode_valid;
   logic                  beat_tick;
   logic [NOTE_WIDTH-1:0] word_note;
   logic [LEN_WIDTH-1:0]  word_len;

   assign mode_valid = is_play_mode(current_state);
   assign word_note  = data_in[NOTE_WIDTH-1:0];
   assign word_len   = data_in[NOTE_WIDTH +: LEN_WIDTH];

   song_player_sequencer_beat_timer #(
      .BEAT_CYCLES(BEAT_CYCLES)
   ) u_beat_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (state_q != S_PLAY),
      .en_i       ((state_q == S_PLAY) && !pause),
      .tempo_sel_i(tempo_sel),
      .beat_tick_o(beat_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         note_q        <= '0;
         len_q         <= '0;
         beat_cnt_q    <= '0;
         tmo_q         <= '0;
         gap_cnt_q     <= '0;
         read_en_q     <= 1'b0;
         read_rst_q    <= 1'b0;
         note_out_q    <= '0;
         note_valid_q  <= 1'b0;
         playing_q     <= 1'b0;
         song_done_q   <= 1'b0;
         fetch_error_q <= 1'b0;
         note_index_q  <= '0;
      end else begin
         read_en_q   <= 1'b0;
         read_rst_q  <= 1'b0;
         song_done_q <= 1'b0;
         if (stop || !mode_valid) begin
            state_q       <= S_IDLE;
            note_out_q    <= '0;
            note_valid_q  <= 1'b0;
            playing_q     <= 1'b0;
            fetch_error_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_ERR: begin
                  if (start) begin
                     state_q       <= S_REWIND;
                     read_rst_q    <= 1'b1;
                     playing_q     <= 1'b1;
                     fetch_error_q <= 1'b0;
                     note_index_q  <= '0;
                  end
               end
               S_REWIND: begin
                  state_q   <= S_FETCH;
                  read_en_q <= 1'b1;
               end
               S_FETCH: begin
                  state_q <= S_WAIT;
                  tmo_q   <= '0;
               end
               S_WAIT: begin
                  if (output_ready) begin
                     if (data_in == DATA_WIDTH'(END_OF_SONG)) begin
                        state_q     <= S_IDLE;
                        song_done_q <= 1'b1;
                        playing_q   <= 1'b0;
                     end else begin
                        state_q      <= S_PLAY;
                        note_q       <= word_note;
                        len_q        <= word_len;
                        beat_cnt_q   <= '0;
                        note_index_q <= note_index_q + 8'd1;
                        note_out_q   <= word_note;
                        note_valid_q <= (word_note != '0);
                     end
                  end else if (tmo_q >= TMO_LAST) begin
                     state_q       <= S_ERR;
                     fetch_error_q <= 1'b1;
                     playing_q     <= 1'b0;
                  end else begin
                     tmo_q <= tmo_q + TW'(1);
                  end
               end
               S_PLAY: begin
                  if (pause) begin
                     note_out_q   <= '0;
                     note_valid_q <= 1'b0;
                  end else if (beat_tick && (beat_cnt_q == len_q)) begin
                     state_q      <= S_GAP;
                     gap_cnt_q    <= '0;
                     note_out_q   <= '0;
                     note_valid_q <= 1'b0;
                  end else begin
                     if (beat_tick) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                     note_out_q   <= note_q;
                     note_valid_q <= (note_q != '0);
                  end
               end
               S_GAP: begin
                  if (!pause) begin
                     if (gap_cnt_q >= GAP_LAST) begin
                        state_q   <= S_FETCH;
                        read_en_q <= 1'b1;
                     end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign read_en     = read_en_q;
   assign read_rst    = read_rst_q;
   assign note_out    = note_out_q;
   assign note_valid  = note_valid_q;
   assign playing     = playing_q;
   assign song_done   = song_done_q;
   assign fetch_error = fetch_error_q;
   assign note_index  = note_index_q;

endmodule
